matmul_mem_sequencer: RTL
=========================

// Module: matmul_mem_sequencer
// PURPOSE
//  Sequences one C = A x B matrix multiply held in the shared 4-port 256x16 data memory.
//  Reads header M,K,N, streams A/B operands through a single 16-bit MAC and writes C back.
//  Sits between the top-level start/done control and the memory's four ports.
//  Port roles: 0 = A read, 1 = B read, 2 = C write, 3 = header read.
// PARAMETERS
//  DATA_W    16  memory word width and accumulator width
//  ADDR_W     8  memory address width; memory depth = 2**ADDR_W
//  HDR_BASE   0  address of M; K at HDR_BASE+1, N at HDR_BASE+2
// PORTS
//  clock        in   1       single clock; all state changes on posedge
//  reset        in   1       asynchronous, active-high; forces IDLE
//  start        in   1       begin job; sampled only in IDLE
//  busy         out  1       high from the cycle after start is accepted until the DONE cycle, inclusive
//  done         out  1       one-cycle pulse: job finished (success or error)
//  error        out  1       one-cycle pulse with done: header rejected, no C writes
//  write_en0..3 out  1 each  memory write enables; only write_en2 is ever 1
//  addr0..3     out  ADDR_W  memory addresses
//  datain0..3   out  DATA_W  memory write data; 0,1,3 held 0
//  dataout0..3  in   DATA_W  registered memory read data, valid 1 cycle after its address
// BEHAVIOUR
//  - Memory model: write-or-read per port on posedge; read data appears the cycle after the address.
//  - All outputs registered. Reset value of every output = 0. Internal state on reset: IDLE, acc = 0.
//  - Layout: A_BASE = HDR_BASE+3 (MxK, row-major); B_BASE = A_BASE+M*K (KxN);
//    C_BASE = B_BASE+K*N (MxN). Element order: i outer, j inner.
//  - FSM states:
//    IDLE  -> HDR on start.
//    HDR   3 cycles; addr3 = HDR_BASE+0, 1, 2.
//    HWAIT 1 cycle; captures N.
//    CHECK 1 cycle; -> ERR or RUN.
//    RUN   K cycles; issue k = 0..K-1.
//          addr0 = A_BASE+i*K+k, addr1 = B_BASE+k*N+j.
//    DRAIN 1 cycle; last MAC.
//    WRITE 1 cycle; write_en2 = 1, addr2 = C_BASE+i*N+j, datain2 = acc; acc cleared.
//          -> RUN (next element) or DONE.
//    DONE  1 cycle; done = 1, then -> IDLE.
//    ERR   1 cycle; done = 1 and error = 1, then -> IDLE.
//  - MAC: at the end of each cycle following a RUN issue, acc <= acc + low DATA_W bits of (dataout0*dataout1).
//    acc wraps mod 2**DATA_W; no saturation, no overflow flag.
//  - Latency: 5 header cycles, then K+2 cycles per C element.
//    done is asserted 5 + M*N*(K+2) + 1 cycles after the start-sample cycle.
//  - CHECK rejects the header (-> ERR) if any of the following holds:
//    * M, K or N is 0
//    * any of M, K, N has nonzero bits [15:8]
//    * 3 + M*K + K*N + M*N > 2**ADDR_W (computed at 18+ bits, no wrap)
//  - start while busy is ignored, with no queueing. start held high re-triggers only from IDLE.
//  - Reset mid-job: write_en2 drops asynchronously. C is left partially written; no done pulse.
//  - write_en2 is never high outside WRITE. Only port 2 writes, and only to C addresses, so no two-port write conflicts.
//  - busy = 0 in IDLE only. done and busy are both 1 in the DONE/ERR cycle.
// TESTING
//  1. Baseline job.
//     Stimulus: mem[0..18] = 2,4,2,1..8,9..16; pulse start.
//     Response: mem[19..22] = 130,140,322,348; done exactly 30 cycles after start; error = 0.
//  2. Zero dimension.
//     Stimulus: header K = 0.
//     Response: done and error pulse at cycle 6; write_en2 never 1; C region unchanged.
//  3. Footprint overflow.
//     Stimulus: M = K = N = 10 (3+300 > 256).
//     Response: error pulse; no writes.
//  4. Wrap arithmetic.
//     Stimulus: M = K = N = 1, A = 300, B = 300.
//     Response: C = 90000 mod 65536 = 24464.
//  5. Reset mid-RUN of element (0,1) in the baseline job.
//     Response: all outputs 0 the same cycle; mem[19] = 130, mem[20] unchanged.
//     Next start recomputes all four C values.
//  6. start pulsed again while busy.
//     Response: ignored; single done pulse; identical C values and timing.

Source files
------------

// File: rtl/matmul_mem_sequencer.sv
// Sequences one C = A x B multiply held in a shared 4-port data memory:
// reads the M,K,N header, validates it, runs a K-cycle MAC per C element and writes C back.
module matmul_mem_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned HDR_BASE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              write_en0,
  output logic              write_en1,
  output logic              write_en2,
  output logic              write_en3,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0] datain0,
  output logic [DATA_W-1:0] datain1,
  output logic [DATA_W-1:0] datain2,
  output logic [DATA_W-1:0] datain3,
  input  logic [DATA_W-1:0] dataout0,
  input  logic [DATA_W-1:0] dataout1,
  input  logic [DATA_W-1:0] dataout2,
  input  logic [DATA_W-1:0] dataout3
);
  localparam int unsigned DIM_W  = 8;
  localparam int unsigned PROD_W = 2 * DIM_W;
  localparam int unsigned FOOT_W = (ADDR_W + 2 > PROD_W + 2) ? ADDR_W + 2 : PROD_W + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HWAIT, S_CHECK, S_RUN, S_DRAIN, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] m_hdr, k_hdr, n_hdr;
  logic [DATA_W-1:0] acc, prod, acc_sum;
  logic [DIM_W-1:0]  m_dim, k_dim, n_dim;
  logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
  logic [1:0]        h_cnt, h_cnt_next;
  logic [ADDR_W-1:0] a_base, b_base, c_base;
  logic [ADDR_W-1:0] a_row, b_col, a_ptr, b_ptr, c_ptr, cur_a, cur_b;
  logic [PROD_W-1:0] mk, kn, mn;
  logic [FOOT_W-1:0] footprint;
  logic              hdr_bad, row_end, last_elem, mac_en;
  logic              unused_dataout2;

  assign write_en0 = 1'b0;
  assign write_en1 = 1'b0;
  assign write_en3 = 1'b0;
  assign datain0   = '0;
  assign datain1   = '0;
  assign datain3   = '0;
  assign unused_dataout2 = ^dataout2;

  // Header decode, memory layout and validity
  assign m_dim     = m_hdr[DIM_W-1:0];
  assign k_dim     = k_hdr[DIM_W-1:0];
  assign n_dim     = n_hdr[DIM_W-1:0];
  assign mk        = PROD_W'(m_dim) * PROD_W'(k_dim);
  assign kn        = PROD_W'(k_dim) * PROD_W'(n_dim);
  assign mn        = PROD_W'(m_dim) * PROD_W'(n_dim);
  assign footprint = FOOT_W'(3) + FOOT_W'(mk) + FOOT_W'(kn) + FOOT_W'(mn);
  assign a_base    = ADDR_W'(HDR_BASE + 3);
  assign b_base    = a_base + ADDR_W'(mk);
  assign c_base    = b_base + ADDR_W'(kn);
  assign hdr_bad   = (m_hdr == '0) || (k_hdr == '0) || (n_hdr == '0)
                   || (|m_hdr[DATA_W-1:DIM_W]) || (|k_hdr[DATA_W-1:DIM_W])
                   || (|n_hdr[DATA_W-1:DIM_W])
                   || (footprint > (FOOT_W'(1) << ADDR_W));

  assign row_end   = (j_cnt == n_dim - DIM_W'(1));
  assign last_elem = row_end && (i_cnt == m_dim - DIM_W'(1));
  assign prod      = dataout0 * dataout1;
  assign acc_sum   = acc + prod;

  always_ff @(posedge clock or posedge reset) begin : state_reg
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state plus the operand addresses to issue if the next cycle is RUN
  always_comb begin : next_logic
    state_next = state;
    h_cnt_next = 2'd0;
    cur_a      = a_ptr;
    cur_b      = b_ptr;
    case (state)
      S_IDLE:  if (start) state_next = S_HDR;
      S_HDR: begin
        h_cnt_next = h_cnt + 2'd1;
        if (h_cnt == 2'd2) state_next = S_HWAIT;
      end
      S_HWAIT: state_next = S_CHECK;
      S_CHECK: begin
        state_next = hdr_bad ? S_ERR : S_RUN;
        cur_a      = a_base;
        cur_b      = b_base;
      end
      S_RUN:   if (k_cnt == k_dim - DIM_W'(1)) state_next = S_DRAIN;
      S_DRAIN: state_next = S_WRITE;
      S_WRITE: begin
        state_next = last_elem ? S_DONE : S_RUN;
        if (row_end) begin
          cur_a = a_row + ADDR_W'(k_dim);
          cur_b = b_base;
        end else begin
          cur_a = a_row;
          cur_b = b_col + ADDR_W'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Header capture, loop counters, pointers and accumulator
  always_ff @(posedge clock or posedge reset) begin : datapath
    if (reset) begin
      m_hdr  <= '0;
      k_hdr  <= '0;
      n_hdr  <= '0;
      acc    <= '0;
      mac_en <= 1'b0;
      h_cnt  <= 2'd0;
      k_cnt  <= '0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      a_row  <= '0;
      b_col  <= '0;
      a_ptr  <= '0;
      b_ptr  <= '0;
      c_ptr  <= '0;
    end else begin
      h_cnt  <= h_cnt_next;
      mac_en <= (state == S_RUN);
      k_cnt  <= (state == S_RUN) ? k_cnt + DIM_W'(1) : '0;
      a_ptr  <= cur_a + ADDR_W'(1);
      b_ptr  <= cur_b + ADDR_W'(n_dim);
      if (state == S_WRITE)  acc <= '0;
      else if (mac_en)       acc <= acc_sum;
      if (state == S_HDR && h_cnt == 2'd1) m_hdr <= dataout3;
      if (state == S_HDR && h_cnt == 2'd2) k_hdr <= dataout3;
      if (state == S_HWAIT)                n_hdr <= dataout3;
      if (state == S_CHECK) begin
        i_cnt <= '0;
        j_cnt <= '0;
        a_row <= a_base;
        b_col <= b_base;
        c_ptr <= c_base;
      end
      if (state == S_WRITE) begin
        c_ptr <= c_ptr + ADDR_W'(1);
        if (row_end) begin
          j_cnt <= '0;
          i_cnt <= i_cnt + DIM_W'(1);
          a_row <= a_row + ADDR_W'(k_dim);
          b_col <= b_base;
        end else begin
          j_cnt <= j_cnt + DIM_W'(1);
          b_col <= b_col + ADDR_W'(1);
        end
      end
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state
  always_ff @(posedge clock or posedge reset) begin : out_regs
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      write_en2 <= 1'b0;
      addr0     <= '0;
      addr1     <= '0;
      addr2     <= '0;
      addr3     <= '0;
      datain2   <= '0;
    end else begin
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE) || (state_next == S_ERR);
      error     <= (state_next == S_ERR);
      write_en2 <= (state_next == S_WRITE);
      addr0     <= (state_next == S_RUN)   ? cur_a   : '0;
      addr1     <= (state_next == S_RUN)   ? cur_b   : '0;
      addr2     <= (state_next == S_WRITE) ? c_ptr   : '0;
      datain2   <= (state_next == S_WRITE) ? acc_sum : '0;
      addr3     <= (state_next == S_HDR) ? ADDR_W'(HDR_BASE) + ADDR_W'(h_cnt_next) : '0;
    end
  end
endmodule
